// File: rtl/band_ratio_pkg.sv
// Shared widths, FSM states and ratio helpers for the band-ratio detector.
package band_ratio_pkg;

  localparam int unsigned WIDTH       = 12;
  localparam int unsigned RATIO_FRAC  = 8;
  localparam int unsigned RATIO_W     = 16;
  localparam int unsigned ALPHA_SHIFT = 2;
  localparam int unsigned ON_COUNT    = 3;
  localparam int unsigned QW          = WIDTH + RATIO_FRAC;
  localparam int unsigned CNT_W       = $clog2(ON_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SMOOTH,
    DECIDE
  } state_t;

  // Clip the full-width quotient to the ratio output range.
  function automatic logic [RATIO_W-1:0] sat_ratio(input logic [QW-1:0] q);
    logic [RATIO_W-1:0] r;
    if (|q[QW-1:RATIO_W]) r = '1;
    else                  r = q[RATIO_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/band_ratio_detector_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, NW cycles per start.
module seq_divider #(
  parameter int unsigned NW = 20,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          last_c,
  output logic [NW-1:0] quot
);

  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  logic [DW-1:0] rem;
  logic [DW-1:0] den_r;
  logic [NW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          run;
  logic [DW:0]   shifted;
  logic [DW:0]   den_x;
  logic          ge;

  // A zero divisor always satisfies ge, so the quotient fills with ones.
  always_comb begin
    shifted = {rem, quo[NW-1]};
    den_x   = {1'b0, den_r};
    ge      = (shifted >= den_x);
  end

  assign last_c = run && (cnt == CW'(NW - 1));
  assign quot   = quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      den_r <= '0;
      quo   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      den_r <= den;
      quo   <= num;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      rem <= ge ? DW'(shifted - den_x) : shifted[DW-1:0];
      quo <= {quo[NW-2:0], ge};
      cnt <= cnt + CW'(1);
      if (last_c) run <= 1'b0;
    end
  end

endmodule

// File: rtl/band_ratio_detector.sv
// Per-frame y0/y1 ratio, first-order IIR smoothing and hysteresis detect
// with a consecutive-frame qualifier.
module band_ratio_detector
  import band_ratio_pkg::*;
(
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic signed [WIDTH-1:0]   i_y0,
  input  logic signed [WIDTH-1:0]   i_y1,
  input  logic                      i_done,
  input  logic        [RATIO_W-1:0] i_thr_hi,
  input  logic        [RATIO_W-1:0] i_thr_lo,
  output logic        [RATIO_W-1:0] o_ratio,
  output logic                      o_ratio_valid,
  output logic                      o_detect,
  output logic                      o_busy,
  output logic                      o_overrun
);

  state_t               state, state_n;
  logic                 done_d;
  logic                 first_frame;
  logic [CNT_W-1:0]     on_cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [RATIO_W-1:0]   s;
  logic [RATIO_W-1:0]   s_next;
  logic [RATIO_W-1:0]   q_sat;
  logic signed [RATIO_W:0] diff, step, s_sum;
  logic [WIDTH-2:0]     a_u, b_u;
  logic                 frame_edge;
  logic                 div_start;
  logic                 div_last;
  logic [QW-1:0]        div_quot;

  assign frame_edge = i_done & ~done_d;

  seq_divider #(
    .NW(QW),
    .DW(QW)
  ) u_div (
    .clk    (i_sys_clk),
    .rst    (i_sys_rst),
    .start  (div_start),
    .num    (QW'(a_u) << RATIO_FRAC),
    .den    (QW'(b_u)),
    .last_c (div_last),
    .quot   (div_quot)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (frame_edge) begin
          div_start = 1'b1;
          state_n   = DIV;
        end
      end
      DIV:     if (div_last) state_n = SMOOTH;
      SMOOTH:  state_n = DECIDE;
      DECIDE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Clamp negatives to zero; smoothing step uses a signed one-bit-wider difference.
  always_comb begin
    a_u     = i_y0[WIDTH-1] ? '0 : i_y0[WIDTH-2:0];
    b_u     = i_y1[WIDTH-1] ? '0 : i_y1[WIDTH-2:0];
    q_sat   = sat_ratio(div_quot);
    diff    = $signed({1'b0, q_sat}) - $signed({1'b0, s});
    step    = diff >>> ALPHA_SHIFT;
    s_sum   = $signed({1'b0, s}) + step;
    s_next  = first_frame ? q_sat : s_sum[RATIO_W-1:0];
    cnt_inc = (on_cnt == CNT_W'(ON_COUNT)) ? on_cnt : on_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      done_d        <= 1'b0;
      first_frame   <= 1'b1;
      on_cnt        <= '0;
      s             <= '0;
      o_ratio       <= '0;
      o_ratio_valid <= 1'b0;
      o_detect      <= 1'b0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      done_d        <= i_done;
      o_busy        <= (state_n != IDLE);
      o_overrun     <= frame_edge && (state != IDLE);
      o_ratio_valid <= (state == DECIDE);
      if (state == SMOOTH) begin
        s           <= s_next;
        first_frame <= 1'b0;
      end
      if (state == DECIDE) begin
        o_ratio <= s;
        if (s >= i_thr_hi) begin
          on_cnt <= cnt_inc;
          if (cnt_inc == CNT_W'(ON_COUNT)) o_detect <= 1'b1;
        end else begin
          on_cnt <= '0;
          if (s < i_thr_lo) o_detect <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_band_ratio_detector.sv
// Directed bench for band_ratio_detector with hand-computed expected ratios.
module tb_band_ratio_detector;

  logic               clk;
  logic               rst;
  logic signed [11:0] y0, y1;
  logic               done;
  logic [15:0]        thr_hi, thr_lo;
  logic [15:0]        ratio;
  logic               valid, detect, busy, overrun;

  int tests  = 0;
  int failed = 0;

  band_ratio_detector dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_y0          (y0),
    .i_y1          (y1),
    .i_done        (done),
    .i_thr_hi      (thr_hi),
    .i_thr_lo      (thr_lo),
    .o_ratio       (ratio),
    .o_ratio_valid (valid),
    .o_detect      (detect),
    .o_busy        (busy),
    .o_overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    done = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  // Raise done for one cycle, then wait (bounded) for the valid pulse.
  task automatic run_frame(input int a, input int b, output int lat, output int bcnt);
    y0   = 12'(a);
    y1   = 12'(b);
    done = 1'b1;
    tick();
    done = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic frame_check(input string tag, input int a, input int b,
                             input int exp_ratio, input logic exp_det);
    int lat, bcnt;
    run_frame(a, b, lat, bcnt);
    check({tag, "_lat"}, 32'(lat), 32'd22);
    check({tag, "_ratio"}, {16'd0, ratio}, 32'(exp_ratio));
    check({tag, "_detect"}, {31'd0, detect}, {31'd0, exp_det});
  endtask

  initial begin
    int lat, bcnt, vcnt, ocnt;
    logic [15:0] seen;

    y0 = '0; y1 = '0; done = 1'b0; rst = 1'b0;
    thr_hi = 16'hFFFF;
    thr_lo = 16'd0;

    do_reset();
    check("rst_ratio",   {16'd0, ratio},   32'd0);
    check("rst_valid",   {31'd0, valid},   32'd0);
    check("rst_detect",  {31'd0, detect},  32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Basic 256/64 = 4.0 in Q8
    run_frame(256, 64, lat, bcnt);
    check("basic_lat",   32'(lat),       32'd22);
    check("basic_busy",  32'(bcnt),      32'd22);
    check("basic_ratio", {16'd0, ratio}, 32'd1024);
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    tick();
    check("basic_valid_pulse", {31'd0, valid}, 32'd0);

    do_reset();
    frame_check("div0", 100, 0, 65535, 1'b0);

    do_reset();
    frame_check("neg_clamp", -5, 10, 0, 1'b0);

    do_reset();
    frame_check("iir0", 256, 64, 1024, 1'b0);
    frame_check("iir1", 0,   64, 768,  1'b0);
    frame_check("iir2", 0,   64, 576,  1'b0);

    // Hysteresis: 512 / 256
    do_reset();
    thr_hi = 16'd512;
    thr_lo = 16'd256;
    frame_check("hy1", 256, 64, 1024, 1'b0);
    frame_check("hy2", 256, 64, 1024, 1'b0);
    frame_check("hy3", 256, 64, 1024, 1'b1);
    frame_check("hy4", 0,   64, 768,  1'b1);
    frame_check("hy5", 0,   64, 576,  1'b1);
    frame_check("hy6", 0,   64, 432,  1'b1);
    frame_check("hy7", 0,   64, 324,  1'b1);
    frame_check("hy8", 0,   64, 243,  1'b0);

    // A sub-threshold frame restarts the qualifier count
    do_reset();
    thr_hi = 16'd900;
    thr_lo = 16'd256;
    frame_check("rs1", 256,  64, 1024,  1'b0);
    frame_check("rs2", 256,  64, 1024,  1'b0);
    frame_check("rs3", 0,    64, 768,   1'b0);
    frame_check("rs4", 2047, 1,  16959, 1'b0);
    frame_check("rs5", 2047, 1,  29103, 1'b0);
    frame_check("rs6", 2047, 1,  38211, 1'b1);
    thr_hi = 16'hFFFF;
    thr_lo = 16'd0;

    // Overrun mid-DIV
    do_reset();
    y0 = 12'sd256; y1 = 12'sd64; done = 1'b1;
    tick();
    done = 1'b0;
    repeat (9) tick();
    y0 = 12'sd0; done = 1'b1;
    tick();
    check("ovr_pulse", {31'd0, overrun}, 32'd1);
    done = 1'b0;
    tick();
    check("ovr_one_cycle", {31'd0, overrun}, 32'd0);
    vcnt = 0; ocnt = 0; seen = '0;
    repeat (30) begin
      tick();
      if (valid === 1'b1) begin vcnt++; seen = ratio; end
      if (overrun === 1'b1) ocnt++;
    end
    check("ovr_valid_count", 32'(vcnt), 32'd1);
    check("ovr_extra_pulses", 32'(ocnt), 32'd0);
    check("ovr_ratio", {16'd0, seen}, 32'd1024);

    // Edge landing in DECIDE is dropped; the next cycle is accepted
    do_reset();
    y0 = 12'sd256; y1 = 12'sd64; done = 1'b1;
    tick();
    done = 1'b0;
    repeat (21) tick();
    check("dec_pre_valid", {31'd0, valid}, 32'd0);
    done = 1'b1;
    tick();
    check("dec_valid",   {31'd0, valid},   32'd1);
    check("dec_overrun", {31'd0, overrun}, 32'd1);
    check("dec_ratio",   {16'd0, ratio},   32'd1024);
    done = 1'b0;
    tick();
    check("dec_idle_busy", {31'd0, busy},    32'd0);
    check("dec_ovr_clear", {31'd0, overrun}, 32'd0);
    frame_check("acc_b", 0, 64, 768, 1'b0);
    run_frame(0, 64, lat, bcnt);
    check("acc_c_lat",   32'(lat),       32'd22);
    check("acc_c_busy",  32'(bcnt),      32'd22);
    check("acc_c_ratio", {16'd0, ratio}, 32'd576);

    // Reset during DIV aborts the frame and re-arms first-frame load
    do_reset();
    frame_check("ab_pre", 256, 64, 1024, 1'b0);
    y0 = 12'sd0; y1 = 12'sd64; done = 1'b1;
    tick();
    done = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vcnt = 0;
    repeat (30) begin
      tick();
      if (valid === 1'b1) vcnt++;
    end
    check("ab_no_valid", 32'(vcnt),      32'd0);
    check("ab_busy",     {31'd0, busy},  32'd0);
    check("ab_ratio",    {16'd0, ratio}, 32'd0);
    frame_check("ab_first", 512, 64, 2048, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
